alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl_if.sv | 44 ++++
 rtl/alarm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Alarm controller signal bundle: panel/time inputs plus the controller's
// registered outputs. The controller takes the slave view and the panel
// (or bench) drives the master view.
interface alarm_ctrl_if;
  logic        alarm_ctrl_tick_1hz;
  logic        alarm_ctrl_min_tick;
  logic [15:0] alarm_ctrl_time;
  logic        alarm_ctrl_mode;
  logic        alarm_ctrl_left;
  logic        alarm_ctrl_right;
  logic        alarm_ctrl_up;
  logic        alarm_ctrl_down;
  logic        alarm_ctrl_snooze;
  logic        alarm_ctrl_stop;
  logic        alarm_ctrl_arm;
  logic        alarm_ctrl_clk_en;
  logic        alarm_ctrl_load;
  logic [15:0] alarm_ctrl_load_time;
  logic [3:0]  alarm_ctrl_digit_sel;
  logic [15:0] alarm_ctrl_alarm;
  logic [15:0] alarm_ctrl_disp;
  logic        alarm_ctrl_ring;
  logic [2:0]  alarm_ctrl_state;

  modport master (
    output alarm_ctrl_tick_1hz, alarm_ctrl_min_tick, alarm_ctrl_time,
           alarm_ctrl_mode, alarm_ctrl_left, alarm_ctrl_right,
           alarm_ctrl_up, alarm_ctrl_down, alarm_ctrl_snooze,
           alarm_ctrl_stop, alarm_ctrl_arm,
    input  alarm_ctrl_clk_en, alarm_ctrl_load, alarm_ctrl_load_time,
           alarm_ctrl_digit_sel, alarm_ctrl_alarm, alarm_ctrl_disp,
           alarm_ctrl_ring, alarm_ctrl_state
  );

  modport slave (
    input  alarm_ctrl_tick_1hz, alarm_ctrl_min_tick, alarm_ctrl_time,
           alarm_ctrl_mode, alarm_ctrl_left, alarm_ctrl_right,
           alarm_ctrl_up, alarm_ctrl_down, alarm_ctrl_snooze,
           alarm_ctrl_stop, alarm_ctrl_arm,
    output alarm_ctrl_clk_en, alarm_ctrl_load, alarm_ctrl_load_time,
           alarm_ctrl_digit_sel, alarm_ctrl_alarm, alarm_ctrl_disp,
           alarm_ctrl_ring, alarm_ctrl_state
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: time/alarm editing through a BCD edit buffer,
// alarm match edge detection, ringing with timeout and minute-based snooze.
// Every output is a register loaded from the next-state values.
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic        alarm_ctrl_clk,
  input  logic        alarm_ctrl_rst,
  alarm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RING      = 3'd3,
    SNOOZE    = 3'd4
  } state_e;

  localparam logic [15:0] RING_LIMIT  = 16'(RING_TIMEOUT_S);
  localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_MIN);
  localparam logic [15:0] ALARM_RESET = 16'h0700;

  state_e      state_q, state_d;
  logic [15:0] buffer_q, buffer_d;
  logic [15:0] alarm_q, alarm_d;
  logic [15:0] load_time_q, load_time_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] ring_cnt_q, ring_cnt_d;
  logic [15:0] snooze_cnt_q, snooze_cnt_d;
  logic [3:0]  digit_sel_q, digit_sel_d;
  logic        load_q, load_d;
  logic        ring_q, ring_d;
  logic        clk_en_q, clk_en_d;
  logic        match_q, match_d;
  logic        match, trigger, set_mode_q, set_mode_d;

  // One BCD digit step with wrap: up past max goes to 0, down from 0 goes to max.
  function automatic logic [3:0] digit_step(input logic [3:0] d, input logic [3:0] max,
                                            input logic inc);
    logic [3:0] r;
    if (inc) r = (d >= max) ? 4'd0 : d + 4'd1;
    else     r = ((d == 4'd0) || (d > max)) ? max : d - 4'd1;
    return r;
  endfunction

  // Apply an up/down edit to the selected digit, clamping H0 when H1 reaches 2.
  function automatic logic [15:0] edit_buffer(input logic [15:0] v, input logic [3:0] sel,
                                              input logic up, input logic down);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = v;
    if (up ^ down) begin
      case (sel)
        4'b0001: m0 = digit_step(m0, 4'd9, up);
        4'b0010: m1 = digit_step(m1, 4'd5, up);
        4'b0100: h0 = digit_step(h0, (h1 == 4'd2) ? 4'd3 : 4'd9, up);
        4'b1000: begin
          h1 = digit_step(h1, 4'd2, up);
          if ((h1 == 4'd2) && (h0 > 4'd3)) h0 = 4'd3;
        end
        default: ;
      endcase
    end
    return {h1, h0, m1, m0};
  endfunction

  assign match      = (bus.alarm_ctrl_time == alarm_q) && bus.alarm_ctrl_arm;
  assign trigger    = match && !match_q;
  assign set_mode_q = (state_q == SET_TIME) || (state_q == SET_ALARM);
  assign set_mode_d = (state_d == SET_TIME) || (state_d == SET_ALARM);

  // Next-state and next-output logic for the mode FSM and its counters.
  always_comb begin
    state_d      = state_q;
    buffer_d     = buffer_q;
    alarm_d      = alarm_q;
    load_time_d  = load_time_q;
    digit_sel_d  = digit_sel_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    load_d       = 1'b0;
    // Held high through the set modes so a match already true on exit cannot ring.
    match_d      = match || set_mode_q;

    case (state_q)
      RUN: begin
        if (trigger) begin
          state_d    = RING;
          ring_cnt_d = 16'd0;
        end else if (bus.alarm_ctrl_mode) begin
          state_d     = SET_TIME;
          buffer_d    = bus.alarm_ctrl_time;
          digit_sel_d = 4'b0001;
        end
      end
      SET_TIME, SET_ALARM: begin
        if (bus.alarm_ctrl_mode) begin
          if (state_q == SET_TIME) begin
            state_d     = SET_ALARM;
            load_d      = 1'b1;
            load_time_d = buffer_q;
            buffer_d    = alarm_q;
            digit_sel_d = 4'b0001;
          end else begin
            state_d     = RUN;
            alarm_d     = buffer_q;
            digit_sel_d = 4'b0000;
          end
        end else begin
          buffer_d = edit_buffer(buffer_q, digit_sel_q, bus.alarm_ctrl_up, bus.alarm_ctrl_down);
          if (bus.alarm_ctrl_left && !bus.alarm_ctrl_right)
            digit_sel_d = {digit_sel_q[2:0], digit_sel_q[3]};
          else if (bus.alarm_ctrl_right && !bus.alarm_ctrl_left)
            digit_sel_d = {digit_sel_q[0], digit_sel_q[3:1]};
        end
      end
      RING: begin
        if (bus.alarm_ctrl_stop || !bus.alarm_ctrl_arm) begin
          state_d = RUN;
        end else if (bus.alarm_ctrl_snooze) begin
          state_d      = SNOOZE;
          snooze_cnt_d = SNOOZE_LOAD;
        end else if (bus.alarm_ctrl_tick_1hz) begin
          ring_cnt_d = ring_cnt_q + 16'd1;
          if (ring_cnt_q + 16'd1 >= RING_LIMIT) state_d = RUN;
        end
      end
      SNOOZE: begin
        if (bus.alarm_ctrl_stop || !bus.alarm_ctrl_arm) begin
          state_d = RUN;
        end else if (bus.alarm_ctrl_min_tick) begin
          if (snooze_cnt_q <= 16'd1) begin
            state_d      = RING;
            ring_cnt_d   = 16'd0;
            snooze_cnt_d = 16'd0;
          end else begin
            snooze_cnt_d = snooze_cnt_q - 16'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    clk_en_d = (state_d != SET_TIME);
    ring_d   = (state_d == RING);
    disp_d   = set_mode_d ? buffer_d : bus.alarm_ctrl_time;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge alarm_ctrl_clk) begin
    if (!alarm_ctrl_rst) begin
      state_q      <= RUN;
      buffer_q     <= 16'h0000;
      alarm_q      <= ALARM_RESET;
      load_time_q  <= 16'h0000;
      disp_q       <= 16'h0000;
      ring_cnt_q   <= 16'd0;
      snooze_cnt_q <= 16'd0;
      digit_sel_q  <= 4'b0000;
      load_q       <= 1'b0;
      ring_q       <= 1'b0;
      clk_en_q     <= 1'b1;
      match_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      alarm_q      <= alarm_d;
      load_time_q  <= load_time_d;
      disp_q       <= disp_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      digit_sel_q  <= digit_sel_d;
      load_q       <= load_d;
      ring_q       <= ring_d;
      clk_en_q     <= clk_en_d;
      match_q      <= match_d;
    end
  end

  assign bus.alarm_ctrl_state     = state_q;
  assign bus.alarm_ctrl_clk_en    = clk_en_q;
  assign bus.alarm_ctrl_load      = load_q;
  assign bus.alarm_ctrl_load_time = load_time_q;
  assign bus.alarm_ctrl_digit_sel = digit_sel_q;
  assign bus.alarm_ctrl_alarm     = alarm_q;
  assign bus.alarm_ctrl_disp      = disp_q;
  assign bus.alarm_ctrl_ring      = ring_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a digit-array reference model of the clock.
module tb_alarm_ctrl;

  localparam int SNZ = 5;
  localparam int RTO = 60;

  localparam logic [6:0] B_MODE  = 7'h01;
  localparam logic [6:0] B_LEFT  = 7'h02;
  localparam logic [6:0] B_RIGHT = 7'h04;
  localparam logic [6:0] B_UP    = 7'h08;
  localparam logic [6:0] B_DOWN  = 7'h10;
  localparam logic [6:0] B_SNZ   = 7'h20;
  localparam logic [6:0] B_STOP  = 7'h40;
  localparam logic [6:0] B_NONE  = 7'h00;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic [15:0] curTime;
  logic        curArm;

  // Reference model: state number, digit arrays indexed 0=M0 .. 3=H1.
  int          mState;
  int          mBuf[4];
  int          mAlarm[4];
  int          mLoadTime[4];
  int          mSel;
  int          mRingCnt;
  int          mSnz;
  bit          mLoad;
  bit          mPrev;
  logic [15:0] mDisp;

  alarm_ctrl_if bus ();

  alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_TIMEOUT_S(RTO)) dut (
    .alarm_ctrl_clk(clk),
    .alarm_ctrl_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] packDigits(input int d3, input int d2, input int d1, input int d0);
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic logic [15:0] bcdTime(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic int digitMax(input int idx, input int h1);
    case (idx)
      0: return 9;
      1: return 5;
      2: return (h1 == 2) ? 3 : 9;
      default: return 2;
    endcase
  endfunction

  task automatic modelReset();
    mState = 0;
    mSel = -1;
    mRingCnt = 0;
    mSnz = 0;
    mLoad = 0;
    mPrev = 1;
    mDisp = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      mBuf[i] = 0;
      mLoadTime[i] = 0;
    end
    mAlarm[0] = 0; mAlarm[1] = 0; mAlarm[2] = 7; mAlarm[3] = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic modelStep(input logic rstN, input logic [6:0] btn, input logic tick,
                           input logic minTick, input logic [15:0] tm, input logic arm);
    bit matchNow, rise, setNow, up, down, left, right;
    int k, mx;
    if (!rstN) begin
      modelReset();
      return;
    end
    setNow = (mState == 1) || (mState == 2);
    matchNow = (tm == packDigits(mAlarm[3], mAlarm[2], mAlarm[1], mAlarm[0])) && arm;
    rise = matchNow && !mPrev;
    mPrev = setNow ? 1'b1 : matchNow;
    mLoad = 0;
    up = btn[3]; down = btn[4]; left = btn[1]; right = btn[2];
    case (mState)
      0: begin
        if (rise) begin
          mState = 3; mRingCnt = 0;
        end else if (btn[0]) begin
          mState = 1; mSel = 0;
          for (int i = 0; i < 4; i++) mBuf[i] = int'(tm[4*i +: 4]);
        end
      end
      1, 2: begin
        if (btn[0]) begin
          if (mState == 1) begin
            mLoad = 1; mLoadTime = mBuf; mBuf = mAlarm; mSel = 0; mState = 2;
          end else begin
            mAlarm = mBuf; mSel = -1; mState = 0;
          end
        end else begin
          if (up != down) begin
            k = mSel;
            mx = digitMax(k, mBuf[3]);
            mBuf[k] = up ? (mBuf[k] + 1) % (mx + 1) : (mBuf[k] + mx) % (mx + 1);
            if (k == 3 && mBuf[3] == 2 && mBuf[2] > 3) mBuf[2] = 3;
          end
          if (left != right) mSel = left ? (mSel + 1) % 4 : (mSel + 3) % 4;
        end
      end
      3: begin
        if (btn[6] || !arm) mState = 0;
        else if (btn[5]) begin
          mState = 4; mSnz = SNZ;
        end else if (tick) begin
          mRingCnt++;
          if (mRingCnt == RTO) mState = 0;
        end
      end
      default: begin
        if (btn[6] || !arm) mState = 0;
        else if (minTick) begin
          mSnz--;
          if (mSnz == 0) begin
            mState = 3; mRingCnt = 0;
          end
        end
      end
    endcase
    mDisp = (mState == 1 || mState == 2) ? packDigits(mBuf[3], mBuf[2], mBuf[1], mBuf[0]) : tm;
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("state", 16'(bus.alarm_ctrl_state), 16'(mState));
    checkVal("ring", 16'(bus.alarm_ctrl_ring), 16'(mState == 3));
    checkVal("clk_en", 16'(bus.alarm_ctrl_clk_en), 16'(mState != 1));
    checkVal("load", 16'(bus.alarm_ctrl_load), 16'(mLoad));
    checkVal("load_time", bus.alarm_ctrl_load_time,
             packDigits(mLoadTime[3], mLoadTime[2], mLoadTime[1], mLoadTime[0]));
    checkVal("digit_sel", 16'(bus.alarm_ctrl_digit_sel), (mSel < 0) ? 16'h0 : 16'(1 << mSel));
    checkVal("alarm", bus.alarm_ctrl_alarm, packDigits(mAlarm[3], mAlarm[2], mAlarm[1], mAlarm[0]));
    checkVal("disp", bus.alarm_ctrl_disp, mDisp);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input logic rstN, input logic [6:0] btn, input logic tick,
                               input logic minTick);
    rst = rstN;
    bus.alarm_ctrl_mode     = btn[0];
    bus.alarm_ctrl_left     = btn[1];
    bus.alarm_ctrl_right    = btn[2];
    bus.alarm_ctrl_up       = btn[3];
    bus.alarm_ctrl_down     = btn[4];
    bus.alarm_ctrl_snooze   = btn[5];
    bus.alarm_ctrl_stop     = btn[6];
    bus.alarm_ctrl_tick_1hz = tick;
    bus.alarm_ctrl_min_tick = minTick;
    bus.alarm_ctrl_time     = curTime;
    bus.alarm_ctrl_arm      = curArm;
    @(posedge clk);
    modelStep(rstN, btn, tick, minTick, curTime, curArm);
    #1;
    checkOutput();
  endtask

  task automatic press(input logic [6:0] btn);
    applyStimulus(1'b1, btn, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] rb;
    curTime = 16'h1234;
    curArm  = 1'b0;
    rst     = 1'b0;
    modelReset();

    // Reset state
    applyStimulus(1'b0, B_NONE, 1'b0, 1'b0);
    applyStimulus(1'b0, B_NONE, 1'b0, 1'b0);
    checkVal("reset_alarm", bus.alarm_ctrl_alarm, 16'h0700);
    checkVal("reset_clk_en", 16'(bus.alarm_ctrl_clk_en), 16'h1);

    // Edit time 12:34: M0 up x3, move to M1, M1 down, commit
    press(B_MODE);
    checkVal("enter_set_time", 16'(bus.alarm_ctrl_state), 16'd1);
    repeat (3) press(B_UP);
    press(B_LEFT);
    press(B_DOWN);
    press(B_MODE);
    checkVal("commit_load", 16'(bus.alarm_ctrl_load), 16'h1);
    checkVal("commit_load_time", bus.alarm_ctrl_load_time, 16'h1227);
    checkVal("commit_state", 16'(bus.alarm_ctrl_state), 16'd2);
    press(B_NONE);
    checkVal("load_one_cycle", 16'(bus.alarm_ctrl_load), 16'h0);

    // Alarm edit: 07:00 -> 17:00 -> 19:00 -> H1 up clamps to 23:00
    press(B_RIGHT);
    press(B_UP);
    press(B_RIGHT);
    press(B_UP);
    press(B_UP);
    checkVal("buf_1900", bus.alarm_ctrl_disp, 16'h1900);
    press(B_LEFT);
    press(B_UP);
    checkVal("buf_clamp_2300", bus.alarm_ctrl_disp, 16'h2300);
    press(B_MODE);
    checkVal("alarm_2300", bus.alarm_ctrl_alarm, 16'h2300);
    checkVal("back_to_run", 16'(bus.alarm_ctrl_state), 16'd0);

    // Simultaneous buttons ignored, mode wins over edits
    press(B_MODE);
    press(B_UP | B_DOWN);
    press(B_LEFT | B_RIGHT);
    checkVal("ignored_sel", 16'(bus.alarm_ctrl_digit_sel), 16'h1);
    checkVal("ignored_buf", bus.alarm_ctrl_disp, 16'h1234);
    press(B_MODE | B_UP);
    checkVal("mode_wins_load", bus.alarm_ctrl_load_time, 16'h1234);
    press(B_MODE);
    press(B_MODE);
    press(B_UP);

    // Reset in the middle of SET_TIME
    applyStimulus(1'b0, B_MODE, 1'b0, 1'b0);
    checkVal("rst_state", 16'(bus.alarm_ctrl_state), 16'd0);
    checkVal("rst_clk_en", 16'(bus.alarm_ctrl_clk_en), 16'h1);
    checkVal("rst_digit_sel", 16'(bus.alarm_ctrl_digit_sel), 16'h0);
    checkVal("rst_load", 16'(bus.alarm_ctrl_load), 16'h0);
    checkVal("rst_alarm", bus.alarm_ctrl_alarm, 16'h0700);
    repeat (3) press(B_NONE);

    // Ring at 07:00 and timeout after RTO seconds
    curArm = 1'b1;
    curTime = 16'h0659;
    repeat (3) press(B_NONE);
    curTime = 16'h0700;
    press(B_NONE);
    checkVal("ring_state", 16'(bus.alarm_ctrl_state), 16'd3);
    checkVal("ring_on", 16'(bus.alarm_ctrl_ring), 16'h1);
    press(B_MODE | B_UP | B_LEFT);
    checkVal("ring_ignores_mode", 16'(bus.alarm_ctrl_state), 16'd3);
    for (int i = 1; i <= RTO; i++) begin
      applyStimulus(1'b1, B_NONE, 1'b1, 1'b0);
      if (i == RTO - 1) checkVal("ring_before_timeout", 16'(bus.alarm_ctrl_ring), 16'h1);
      press(B_NONE);
    end
    checkVal("timeout_state", 16'(bus.alarm_ctrl_state), 16'd0);
    checkVal("timeout_ring", 16'(bus.alarm_ctrl_ring), 16'h0);
    repeat (10) press(B_NONE);
    checkVal("no_rering", 16'(bus.alarm_ctrl_state), 16'd0);

    // Stop beats snooze; snooze then re-ring after SNZ minutes; trigger beats mode
    curTime = 16'h0659;
    press(B_NONE);
    curTime = 16'h0700;
    press(B_MODE);
    checkVal("trigger_beats_mode", 16'(bus.alarm_ctrl_state), 16'd3);
    press(B_SNZ | B_STOP);
    checkVal("stop_beats_snooze", 16'(bus.alarm_ctrl_state), 16'd0);
    curTime = 16'h0659;
    press(B_NONE);
    curTime = 16'h0700;
    press(B_NONE);
    press(B_SNZ);
    checkVal("snooze_state", 16'(bus.alarm_ctrl_state), 16'd4);
    checkVal("snooze_quiet", 16'(bus.alarm_ctrl_ring), 16'h0);
    for (int i = 1; i <= SNZ; i++) begin
      applyStimulus(1'b1, B_NONE, 1'b1, 1'b1);
      if (i == SNZ - 1) checkVal("snooze_before_end", 16'(bus.alarm_ctrl_state), 16'd4);
    end
    checkVal("snooze_rering", 16'(bus.alarm_ctrl_state), 16'd3);
    curArm = 1'b0;
    press(B_NONE);
    checkVal("disarm_stops", 16'(bus.alarm_ctrl_state), 16'd0);
    curArm = 1'b1;

    // Setting the alarm equal to the current time must not ring on exit
    curTime = 16'h0800;
    press(B_NONE);
    press(B_MODE);
    press(B_MODE);
    press(B_LEFT);
    press(B_LEFT);
    press(B_UP);
    press(B_MODE);
    checkVal("alarm_0800", bus.alarm_ctrl_alarm, 16'h0800);
    repeat (5) press(B_NONE);
    checkVal("exit_no_ring", 16'(bus.alarm_ctrl_state), 16'd0);

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      rb = B_NONE;
      if ($urandom_range(0, 9) == 0) rb |= B_MODE;
      if ($urandom_range(0, 5) == 0) rb |= B_LEFT;
      if ($urandom_range(0, 5) == 0) rb |= B_RIGHT;
      if ($urandom_range(0, 3) == 0) rb |= B_UP;
      if ($urandom_range(0, 3) == 0) rb |= B_DOWN;
      if ($urandom_range(0, 15) == 0) rb |= B_SNZ;
      if ($urandom_range(0, 31) == 0) rb |= B_STOP;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: curTime = packDigits(mAlarm[3], mAlarm[2], mAlarm[1], mAlarm[0]);
          1: curTime = 16'h0700;
          default: curTime = bcdTime(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
        endcase
      end
      curArm = ($urandom_range(0, 31) != 0);
      applyStimulus(($urandom_range(0, 199) != 0), rb,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
